booth_pp_sender: RTL and testbench
==================================

Name: booth_pp_sender

Overview:
- Clocked Booth radix-4 partial-product source that sits directly upstream of the request-flow-control decoder in the async Booth multiplier pipeline.
- Latches an operand pair and encodes one partial product per multiplier digit.
- Sends each partial product as bundled data with a two-phase request toggle on rout, which the decoder consumes.
- Waits for a two-phase acknowledge from the asynchronous pipeline before sending the next digit.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- SYNC_STAGES, 2, flip-flop depth of the ain synchronizer; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a multiply; sampled in IDLE only.
- a  input  WIDTH  multiplicand, two's complement.
- b  input  WIDTH  multiplier, two's complement.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the last digit is acknowledged.
- rout  output  1  two-phase request; each toggle marks a new valid pp_data.
- ain  input  1  asynchronous two-phase acknowledge from downstream.
- pp_data  output  2*WIDTH  partial product, sign-extended and pre-shifted.
- pp_idx  output  clog2(WIDTH/2) (min 1)  digit index of pp_data.
- pp_last  output  1  high while pp_data is the final digit.
- proto_err  output  1  sticky flag; ain toggled while no request was outstanding.

Behaviour:
- Reset values: busy=0, done=0, rout=0, pp_data=0, pp_idx=0, pp_last=0, proto_err=0. Synchronizer flops and the ack phase register are cleared to 0; FSM goes to IDLE.
- FSM states and transitions:
  - IDLE: start=1 -> latch a, b; clear digit counter; go to ENCODE.
  - ENCODE: register pp_data, pp_idx, pp_last for the current digit; go to SEND.
  - SEND: toggle rout; go to WAIT_ACK.
  - WAIT_ACK: when synchronized ain equals rout, either increment the counter and go to ENCODE, or go to FIN if this was the last digit.
  - FIN: pulse done for one cycle; go to IDLE.
- Bundled-data rule: pp_data, pp_idx and pp_last change only in ENCODE. They are therefore stable for at least one full clk before the rout toggle and stay stable until the matching ack has been synchronized.
- Digit encoding: digit i uses {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - 000 or 111 -> 0.
  - 001 or 010 -> +A.
  - 011 -> +2A.
  - 100 -> -2A.
  - 101 or 110 -> -A.
- Arithmetic: A is sign-extended to 2*WIDTH bits, the selected multiple is formed in two's complement, then shifted left by 2i. Overflow wraps modulo 2^(2*WIDTH). Summing all WIDTH/2 partial products equals a*b mod 2^(2*WIDTH).
- Latency:
  - start accepted at edge N -> rout toggles at edge N+2.
  - Ack resolves SYNC_STAGES edges after ain toggles, ±1 cycle.
  - Next rout toggle follows 2 cycles after the ack resolves.
- Zero digits are still sent, with pp_data=0, so the downstream always sees exactly WIDTH/2 transfers.
- Boundary conditions:
  - start while busy, or in any state other than IDLE, is ignored.
  - A start pulse in the same cycle as done (FIN) is ignored.
  - A synchronized ain toggle outside WAIT_ACK, or an ack in IDLE, sets proto_err. It does not change state; the ack phase register is still updated.
  - Reset mid-operation: abort immediately to reset values. The downstream pipeline must be reset together with this block, so rout=0 and ain=0 agree on phase.
  - Repeated multiplies continue the rout phase; rout is not re-zeroed between operations.

Optional Feature:
- Macro: BOOTH_PP_ACC_EN.
- Defined:
  - Adds output acc of width 2*WIDTH, reset 0, cleared when start is accepted.
  - Each acknowledged pp_data is added to acc, modulo 2^(2*WIDTH).
  - acc holds the full product a*b when done pulses.
  - acc is for self-check only and has no effect on the handshake.
- Undefined: no acc port and no adder; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=3, b=5; ack 3 cycles after each rout toggle -> pp_data sequence 0x0003, 0x000C, 0x0000, 0x0000; pp_last only on idx 3; done after the 4th ack; acc=0x000F if enabled.
- a=0xF9 (-7), b=0xFD (-3) -> pp_data 0xFFF9, 0x001C, 0x0000, 0x0000; sum 0x0015 (21).
- a=0x7F, b=0x80 -> idx 0-2 give 0x0000; idx 3 gives 0xC080 (-16256).
- Ack delayed 20 cycles on digit 1 -> pp_data and pp_idx are stable throughout the wait; rout toggles exactly once per digit; busy stays high.
- ain toggled in IDLE -> proto_err=1 and stays set; a following start still completes normally.
- rst_n asserted in WAIT_ACK of digit 2, then start with a new operand pair -> all outputs return to reset values immediately; the new operation starts cleanly from rout=0 and sends four transfers.

Source files
------------

// File: rtl/booth_pp_sender_if.sv
// ---------------------------------------------------------------------------
// booth_pp_sender_if
// Bundled-data channel between the clocked Booth partial-product source and
// the asynchronous multiplier pipeline.
//
// Signals:
//   rout     two-phase request, each toggle marks a new valid pp_data
//   ain      two-phase acknowledge from the asynchronous side
//   pp_data  partial product, sign-extended and pre-shifted (2*WIDTH bits)
//   pp_idx   digit index of pp_data
//   pp_last  high while pp_data is the final digit
//
// Modports:
//   master   the sender (drives rout and the bundle, receives ain)
//   slave    the downstream decoder (receives bundle, drives ain)
// ---------------------------------------------------------------------------
interface booth_pp_sender_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
);
    logic               rout;
    logic               ain;
    logic [2*WIDTH-1:0] pp_data;
    logic [IDXW-1:0]    pp_idx;
    logic               pp_last;

    modport master (
        output rout,
        output pp_data,
        output pp_idx,
        output pp_last,
        input  ain
    );

    modport slave (
        input  rout,
        input  pp_data,
        input  pp_idx,
        input  pp_last,
        output ain
    );
endinterface

// File: rtl/booth_pp_sender.sv
// ---------------------------------------------------------------------------
// booth_pp_sender
// Clocked Booth radix-4 partial-product source. Latches an operand pair,
// encodes one partial product per multiplier digit and hands each one to the
// asynchronous pipeline as bundled data with a two-phase request (rout). The
// next digit is only sent after the matching two-phase acknowledge (ain) has
// been synchronized into the clk domain.
//
// Parameters:
//   WIDTH        operand width, even and >= 4
//   SYNC_STAGES  depth of the ain synchronizer, >= 2
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        one-cycle request to begin a multiply (IDLE only)
//   a, b         multiplicand / multiplier, two's complement
//   busy         high from the cycle after start is accepted until done
//   done         one-cycle pulse after the last digit is acknowledged
//   proto_err    sticky: ain toggled while no request was outstanding
//   acc          running sum of acknowledged partial products
//                (only when BOOTH_PP_ACC_EN is defined)
//   bus          booth_pp_sender_if.master: rout, ain, pp_data, pp_idx,
//                pp_last
//
// Optional feature macro: BOOTH_PP_ACC_EN
// ---------------------------------------------------------------------------
module booth_pp_sender #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 proto_err,
`ifdef BOOTH_PP_ACC_EN
    output logic [2*WIDTH-1:0]   acc,
`endif
    booth_pp_sender_if.master    bus
);

    localparam int NDIG = WIDTH / 2;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        SEND,
        WAIT_ACK,
        FIN
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [IDXW-1:0]        cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ain_s;
    logic                   ack_phase;
    logic                   rout_q;
    logic [PW-1:0]          pp_data_q;
    logic [IDXW-1:0]        pp_idx_q;
    logic                   pp_last_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   proto_q;

    logic                   accept;
    logic                   ack_ok;
    logic                   last_digit;
    logic [WIDTH:0]         bx;
    logic [2:0]             trip;
    logic [PW-1:0]          a_ext;
    logic [PW-1:0]          mult;
    logic [PW-1:0]          pp_next;

    assign ain_s      = sync[SYNC_STAGES-1];
    assign last_digit = (cnt == IDXW'(NDIG - 1));

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. The ack is recognised by phase equality rather than
    // by an edge, so a request is complete once synchronized ain catches up
    // with rout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_ok     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ENCODE;
                end
            end
            ENCODE: begin
                state_next = SEND;
            end
            SEND: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ain_s == rout_q) begin
                    ack_ok     = 1'b1;
                    state_next = last_digit ? FIN : ENCODE;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Booth radix-4 recoding of the current digit. b is extended with the
    // implicit b[-1]=0 below bit 0 so every digit is a plain 3-bit window.
    always_comb begin
        bx    = {b_q, 1'b0};
        trip  = 3'(bx >> {cnt, 1'b0});
        a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        mult  = '0;
        case (trip)
            3'b001, 3'b010: mult = a_ext;
            3'b011:         mult = a_ext << 1;
            3'b100:         mult = -(a_ext << 1);
            3'b101, 3'b110: mult = -a_ext;
            default:        mult = '0;
        endcase
        pp_next = mult << {cnt, 1'b0};
    end

    // Datapath, synchronizer and status flags. The bundle registers are only
    // written in ENCODE, which keeps them stable from one cycle before the
    // rout toggle until the ack has come through the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            sync      <= '0;
            ack_phase <= 1'b0;
            rout_q    <= 1'b0;
            pp_data_q <= '0;
            pp_idx_q  <= '0;
            pp_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], bus.ain};
            ack_phase <= ain_s;
            busy_q    <= (state_next != IDLE);
            done_q    <= (state_next == FIN);

            // Any synchronized ain transition outside WAIT_ACK has no
            // request to answer.
            if ((ain_s != ack_phase) && (state != WAIT_ACK)) begin
                proto_q <= 1'b1;
            end

            if (accept) begin
                a_q <= a;
                b_q <= b;
                cnt <= '0;
            end

            if (state == ENCODE) begin
                pp_data_q <= pp_next;
                pp_idx_q  <= cnt;
                pp_last_q <= last_digit;
            end

            // rout keeps its phase across operations; only reset zeroes it.
            if (state == SEND) begin
                rout_q <= ~rout_q;
            end

            if (ack_ok && !last_digit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BOOTH_PP_ACC_EN
    // Self-check accumulator: sums every acknowledged partial product so it
    // holds a*b by the time done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (ack_ok) begin
            acc <= acc + pp_data_q;
        end
    end
`endif

    assign bus.rout    = rout_q;
    assign bus.pp_data = pp_data_q;
    assign bus.pp_idx  = pp_idx_q;
    assign bus.pp_last = pp_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign proto_err   = proto_q;

endmodule

// File: tb/tb_booth_pp_sender.sv
// ---------------------------------------------------------------------------
// tb_booth_pp_sender
// Self-checking bench for booth_pp_sender (WIDTH=8). Expected partial
// products come from Booth digit values computed arithmetically; a negedge
// monitor checks every transfer and the bundle stability while a request is
// outstanding.
// ---------------------------------------------------------------------------
module tb_booth_pp_sender;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [15:0] pp;
        logic [1:0]  idx;
        logic        last;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic        proto_err;
`ifdef BOOTH_PP_ACC_EN
    logic [15:0] acc;
`endif

    booth_pp_sender_if #(.WIDTH(WIDTH)) bus ();

    booth_pp_sender #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .proto_err (proto_err),
`ifdef BOOTH_PP_ACC_EN
        .acc       (acc),
`endif
        .bus       (bus)
    );

    int          total = 0;
    int          bad   = 0;
    xfer_t       expQ[$];
    xfer_t       cur;
    logic        monRout = 1'b0;
    bit          holding = 1'b0;
    logic [15:0] obsSum;
    logic [15:0] obsPp [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Booth digit d = b[2i-1] + b[2i] - 2*b[2i+1], pp = d*a*4^i.
    function automatic logic [15:0] modelPp(input logic [7:0] ma, input logic [7:0] mb, input int i);
        int d;
        int sa;
        int lo;
        lo = (i == 0) ? 0 : int'(mb[2*i-1]);
        d  = lo + int'(mb[2*i]) - 2 * int'(mb[2*i+1]);
        sa = $signed(ma);
        return 16'((d * sa) * (1 << (2 * i)));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitRout(input logic prev, input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            tick();
            n++;
            if (bus.rout !== prev) ok = 1'b1;
        end
    endtask

    task automatic checkObs(input string name, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        checkOutput({name, "_pp0"}, obsPp[0], e0);
        checkOutput({name, "_pp1"}, obsPp[1], e1);
        checkOutput({name, "_pp2"}, obsPp[2], e2);
        checkOutput({name, "_pp3"}, obsPp[3], e3);
    endtask

    // One complete multiply with a bench-side acknowledging pipeline.
    task automatic applyStimulus(input logic [7:0] ma, input logic [7:0] mb, input int fixedDly,
                                 input int slowIdx, input int slowDly, input bit pokeBusy,
                                 input bit pokeFin);
        int          n;
        bit          ok;
        int          d;
        int          sa;
        int          sb;
        logic        prevRout;
        logic [15:0] prod;
        logic        routAtFin;
        xfer_t       e;
        sa   = $signed(ma);
        sb   = $signed(mb);
        prod = 16'(sa * sb);
        for (int i = 0; i < 4; i++) begin
            e.pp   = modelPp(ma, mb, i);
            e.idx  = 2'(i);
            e.last = (i == 3);
            expQ.push_back(e);
        end
        obsSum   = '0;
        prevRout = bus.rout;
        a        = ma;
        b        = mb;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitRout(prevRout, 12, n, ok);
            checkOutput("rout_toggle_seen", 32'(ok), 32'd1);
            if (i == 0) begin
                checkOutput("start_to_rout", 32'(n), 32'd2);
            end else if (n < 4 || n > 6) begin
                checkOutput("ack_to_rout_4to6", 32'(n), 32'd5);
            end else begin
                checkOutput("ack_to_rout_4to6", 32'(ok), 32'd1);
            end
            prevRout = bus.rout;
            checkOutput("busy_during_xfer", 32'(busy), 32'd1);
            d = (fixedDly >= 0) ? fixedDly : int'($urandom_range(0, 6));
            if (i == slowIdx) d = slowDly;
            for (int k = 0; k < d; k++) begin
                if (pokeBusy && i == 1 && k == 0) begin
                    a     = ~ma;
                    b     = ~mb;
                    start = 1'b1;
                end
                tick();
                start = 1'b0;
                a     = ma;
                b     = mb;
            end
            if (i == slowIdx) begin
                checkOutput("busy_after_slow_ack", 32'(busy), 32'd1);
                checkOutput("rout_single_toggle", 32'(bus.rout), 32'(prevRout));
            end
            bus.ain = ~bus.ain;
        end
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        if (n < 2 || n > 4) checkOutput("ack_to_done_2to4", 32'(n), 32'd3);
        checkOutput("busy_with_done", 32'(busy), 32'd1);
`ifdef BOOTH_PP_ACC_EN
        checkOutput("acc_product", 32'(acc), 32'(prod));
`endif
        routAtFin = bus.rout;
        if (pokeFin) begin
            a     = ~ma;
            b     = mb;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_cleared", 32'(busy), 32'd0);
        if (pokeFin) begin
            repeat (4) tick();
            checkOutput("fin_start_ignored_busy", 32'(busy), 32'd0);
            checkOutput("fin_start_ignored_rout", 32'(bus.rout), 32'(routAtFin));
        end
        checkOutput("transfer_count", 32'(expQ.size()), 32'd0);
        checkOutput("pp_sum_product", 32'(obsSum), 32'(prod));
    endtask

    // Monitor: every rout toggle is a transfer checked against the model;
    // while it is unacknowledged the bundle must not move.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rout !== monRout) begin
                monRout = bus.rout;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_transfer", 32'd1, 32'd0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("pp_data", 32'(bus.pp_data), 32'(cur.pp));
                    checkOutput("pp_idx", 32'(bus.pp_idx), 32'(cur.idx));
                    checkOutput("pp_last", 32'(bus.pp_last), 32'(cur.last));
                    obsSum          = obsSum + bus.pp_data;
                    obsPp[cur.idx]  = bus.pp_data;
                    holding         = 1'b1;
                end
            end else if (holding && bus.rout !== bus.ain) begin
                checkOutput("pp_data_stable", 32'(bus.pp_data), 32'(cur.pp));
                checkOutput("pp_idx_stable", 32'(bus.pp_idx), 32'(cur.idx));
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rout"}, 32'(bus.rout), 32'd0);
        checkOutput({tag, "_pp_data"}, 32'(bus.pp_data), 32'd0);
        checkOutput({tag, "_pp_idx"}, 32'(bus.pp_idx), 32'd0);
        checkOutput({tag, "_pp_last"}, 32'(bus.pp_last), 32'd0);
        checkOutput({tag, "_proto_err"}, 32'(proto_err), 32'd0);
`ifdef BOOTH_PP_ACC_EN
        checkOutput({tag, "_acc"}, 32'(acc), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        bit  ok;
        logic prevRout;
        xfer_t e;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        bus.ain = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();

        // Two ain toggles with nothing outstanding: flag set, phase restored.
        bus.ain = 1'b1;
        repeat (4) tick();
        checkOutput("proto_err_set", 32'(proto_err), 32'd1);
        bus.ain = 1'b0;
        repeat (4) tick();

        applyStimulus(8'd3, 8'd5, 3, -1, 0, 1'b0, 1'b0);
        checkObs("a3b5", 16'h0003, 16'h000C, 16'h0000, 16'h0000);
        checkOutput("proto_err_sticky", 32'(proto_err), 32'd1);

        applyStimulus(8'hF9, 8'hFD, 2, -1, 0, 1'b0, 1'b1);
        checkObs("neg7neg3", 16'hFFF9, 16'h001C, 16'h0000, 16'h0000);

        applyStimulus(8'h7F, 8'h80, 1, -1, 0, 1'b1, 1'b0);
        checkObs("max_min", 16'h0000, 16'h0000, 16'h0000, 16'hC080);

        applyStimulus(8'h5B, 8'hC6, 2, 1, 20, 1'b0, 1'b0);

        // Reset while waiting for the digit-2 ack.
        for (int i = 0; i < 4; i++) begin
            e.pp   = modelPp(8'hA5, 8'h6B, i);
            e.idx  = 2'(i);
            e.last = (i == 3);
            expQ.push_back(e);
        end
        obsSum   = '0;
        prevRout = bus.rout;
        a        = 8'hA5;
        b        = 8'h6B;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitRout(prevRout, 12, n, ok);
            checkOutput("rst_run_toggle", 32'(ok), 32'd1);
            prevRout = bus.rout;
            if (i < 2) begin
                repeat (2) tick();
                bus.ain = ~bus.ain;
            end
        end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checkResetValues("midop_reset");
        expQ.delete();
        monRout = 1'b0;
        holding = 1'b0;
        bus.ain = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(8'h81, 8'h7F, 2, -1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            applyStimulus(8'($urandom), 8'($urandom), -1, -1, 0, 1'b0, 1'b0);
        end
        checkOutput("proto_err_clean", 32'(proto_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
